// File: rtl/aidc_lite_ahb_pkg.sv
// Shared AHB2 encodings and responder state type for the aidc_lite bus masters and slaves.
package aidc_lite_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } ahb_rsp_state_e;

  // An address phase carries a real transfer only for NONSEQ/SEQ.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/aidc_lite_sram_1r1w.sv
// Word storage for the AHB responder: combinational read port, synchronous write port.
module aidc_lite_sram_1r1w #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aidc_lite_ahb_mem_slave.sv
// AHB2 word-addressed memory responder with programmable wait states and
// two-cycle ERROR responses for unsupported or out-of-window accesses.
module aidc_lite_ahb_mem_slave
  import aidc_lite_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  ahb_rsp_state_e    r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic              r_hreadyout;
  logic [1:0]        r_hresp;

  logic              w_can_accept;
  logic              w_accept;
  logic              w_in_win;
  logic              w_err;
  logic              w_we;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_can_accept = (r_state == S_IDLE) | (r_state == S_LAST) | (r_state == S_ERR2);
  assign w_accept     = w_can_accept & hsel & hready & is_active_trans(htrans);

  // The window is size-aligned, so membership is a compare of the bits above it.
  assign w_in_win = (haddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_err    = (hsize != SIZE_WORD) | (haddr[1:0] != 2'b00) | ~w_in_win;

  assign w_we     = (r_state == S_LAST) & r_write & ~rst;
  assign w_unused = ^{hburst, htrans[0]};

  aidc_lite_sram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (hwdata),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE, S_LAST, S_ERR2: begin
          if (w_accept) begin
            r_addr  <= haddr[ADDR_W+1:2];
            r_write <= hwrite;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_CYCLES > 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= WAIT_INIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              r_state     <= S_LAST;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_LAST;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = ((r_state == S_LAST) && !r_write) ? w_rdata : '0;

endmodule
